// File: rtl/vin_frame_read_if.sv
// vin_frame_read_if: DDR2 burst-read port between the frame reader and the memory arbiter.
interface vin_frame_read_if #(
    parameter int MEM_DATA_BITS = 64
);
    logic                     rd_burst_req;
    logic [9:0]               rd_burst_len;
    logic [23:0]              rd_burst_addr;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     burst_finish;
    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data_valid, rd_burst_data, burst_finish
    );
    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data_valid, rd_burst_data, burst_finish
    );
endinterface

// File: rtl/vin_frame_read_ctrl.sv
// vin_frame_read_ctrl: prefetches frame-buffer lines by DDR2 burst reads into a show-ahead
// FIFO and unpacks each 64-bit word into four 16-bit YC pixels paced by vout_de.
module vin_frame_read_ctrl #(
    parameter int MEM_DATA_BITS = 64,
    parameter bit INTERLACE     = 1'b1,
    parameter int BURST_LEN     = 128,
    parameter int FIFO_AW       = 8
) (
    input  logic             vin_clk,
    input  logic             rst_n,
    input  logic             vout_vs,
    input  logic             vout_f,
    input  logic             vout_de,
    input  logic [11:0]      vout_width,
    input  logic [11:0]      vout_height,
    input  logic [1:0]       base_addr,
    input  logic [1:0]       frame_addr,
    output logic [15:0]      vout_data,
    output logic             underflow,
    vin_frame_read_if.master mem
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {IDLE, LINE_START, BURSTING, BURST_END, LINE_END} state_t;

    state_t                   state, state_nx;
    logic                     vs_d, frame_flag, drain, enter_burst;
    logic [1:0]               rd_frame;
    logic [9:0]               words_per_line, remain, rem_src, burst_cap, room;
    logic [11:0]              line, pcnt;
    logic [23:0]              line_addr;
    logic [FIFO_AW:0]         used;
    logic [FIFO_AW-1:0]       wr_ptr, rd_ptr;
    logic [MEM_DATA_BITS-1:0] fifo [DEPTH];
    logic [MEM_DATA_BITS-1:0] head;
    logic                     empty, full, push, pop, last_px;

    // frame slot sits at bits [20:19] in both maps; the field bit splits lines when interlaced
    assign line_addr = INTERLACE ? {1'b0, base_addr, rd_frame, line[9:0], vout_f, 8'd0}
                                 : {base_addr, 1'b0, rd_frame, line[9:0], 9'd0};

    assign empty   = used == '0;
    assign full    = used == (FIFO_AW+1)'(DEPTH);
    assign last_px = pcnt == vout_width - 12'd1;
    assign head    = fifo[rd_ptr];
    assign push    = mem.rd_burst_data_valid & ~drain & ~full & ~frame_flag;
    assign pop     = vout_de & ~empty & (pcnt[1:0] == 2'd3 | last_px);

    always_comb begin
        rem_src     = (state == LINE_START) ? words_per_line : remain;
        burst_cap   = (rem_src > 10'(BURST_LEN)) ? 10'(BURST_LEN) : rem_src;
        room        = 10'((FIFO_AW+1)'(DEPTH) - used);
        state_nx    = state;
        unique case (state)
            IDLE:       state_nx = (!drain && line < vout_height && room >= 10'(BURST_LEN)) ? LINE_START : IDLE;
            LINE_START: state_nx = BURSTING;
            BURSTING:   state_nx = mem.burst_finish ? BURST_END : BURSTING;
            BURST_END:  state_nx = (remain == '0) ? LINE_END : (room >= burst_cap) ? BURSTING : BURST_END;
            LINE_END:   state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        enter_burst = state_nx == BURSTING && state != BURSTING;
    end

    always_ff @(posedge vin_clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= frame_flag ? IDLE : state_nx;

    always_ff @(posedge vin_clk or negedge rst_n)
        if (!rst_n) begin
            vs_d              <= 1'b0;
            frame_flag        <= 1'b0;
            drain             <= 1'b0;
            rd_frame          <= '0;
            words_per_line    <= '0;
            remain            <= '0;
            line              <= '0;
            mem.rd_burst_req  <= 1'b0;
            mem.rd_burst_len  <= '0;
            mem.rd_burst_addr <= '0;
        end else begin
            vs_d       <= vout_vs;
            frame_flag <= vout_vs & ~vs_d;
            if (frame_flag) begin
                // a burst still in flight is abandoned; wait for its finish before reissuing
                drain            <= (drain | state == BURSTING) & ~mem.burst_finish;
                rd_frame         <= frame_addr;
                words_per_line   <= vout_width[11:2] + 10'(vout_width[1:0] != 2'd0);
                line             <= '0;
                mem.rd_burst_req <= 1'b0;
            end else begin
                if (mem.burst_finish)
                    drain <= 1'b0;
                if (state == IDLE && state_nx == LINE_START)
                    mem.rd_burst_addr <= line_addr;
                if (state == LINE_START)
                    remain <= words_per_line;
                if (state == BURSTING && mem.burst_finish) begin
                    remain            <= (remain > mem.rd_burst_len) ? remain - mem.rd_burst_len : '0;
                    mem.rd_burst_addr <= mem.rd_burst_addr + 24'(mem.rd_burst_len);
                end
                if (state == LINE_END)
                    line <= line + 12'd1;
                if (enter_burst) begin
                    mem.rd_burst_req <= 1'b1;
                    mem.rd_burst_len <= burst_cap;
                end else if (mem.rd_burst_data_valid | mem.burst_finish | state == IDLE)
                    mem.rd_burst_req <= 1'b0;
            end
        end

    always_ff @(posedge vin_clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            pcnt      <= '0;
            vout_data <= '0;
            underflow <= 1'b0;
        end else if (frame_flag) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            pcnt      <= '0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_AW'(push);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            used   <= used + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            if (vout_de) begin
                pcnt      <= last_px ? 12'd0 : pcnt + 12'd1;
                vout_data <= empty ? 16'h0000 : head[{pcnt[1:0], 4'd0} +: 16];
            end
            if (vout_de & empty)
                underflow <= 1'b1;
        end

    always_ff @(posedge vin_clk)
        if (push) fifo[wr_ptr] <= mem.rd_burst_data;
endmodule

// File: tb/tb_vin_frame_read_ctrl.sv
// tb_vin_frame_read_ctrl: randomized memory/video stimulus against a line-level reference model;
// a second, interlaced instance is checked on its request addresses only.
`timescale 1ns/1ps
module tb_vin_frame_read_ctrl;
    typedef struct {
        logic [23:0] a;
        logic [9:0]  n;
    } burst_t;

    logic        vin_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vout_vs = 1'b0, vout_f = 1'b1, vout_de = 1'b0;
    logic [11:0] vout_width = 12'd640, vout_height = 12'd0;
    logic [1:0]  base_addr = 2'd0, frame_addr = 2'd0;
    logic [15:0] vout_data, vout_data2;
    logic        underflow, underflow2;
    int          n_cmp = 0, n_bad = 0;
    int          gap_pct = 20;
    burst_t      q1[$], q2[$];
    logic        busy1 = 1'b0, busy2 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;
    logic [23:0] a1;
    int          n1, c1, lat1, lat2;
    logic        pend = 1'b0;
    logic [15:0] pend_exp = '0;

    vin_frame_read_if mif ();
    vin_frame_read_if mif2 ();

    always #5 vin_clk = ~vin_clk;

    vin_frame_read_ctrl #(.INTERLACE(1'b0)) dut (
        .vin_clk(vin_clk), .rst_n(rst_n), .vout_vs(vout_vs), .vout_f(vout_f), .vout_de(vout_de),
        .vout_width(vout_width), .vout_height(vout_height), .base_addr(base_addr),
        .frame_addr(frame_addr), .vout_data(vout_data), .underflow(underflow), .mem(mif)
    );

    vin_frame_read_ctrl #(.INTERLACE(1'b1)) dut_il (
        .vin_clk(vin_clk), .rst_n(rst_n), .vout_vs(vout_vs), .vout_f(vout_f), .vout_de(vout_de),
        .vout_width(vout_width), .vout_height(vout_height), .base_addr(2'd0),
        .frame_addr(2'd1), .vout_data(vout_data2), .underflow(underflow2), .mem(mif2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] addr_of(input bit il, input int b, input int fr, input int f, input int l);
        return il ? 24'((b << 21) | (fr << 19) | (l << 9) | (f << 8))
                  : 24'((b << 22) | (fr << 19) | (l << 9));
    endfunction

    function automatic logic [63:0] memw(input logic [23:0] a);
        if (a == 24'h500000) return 64'h4444_3333_2222_1111;
        return {a[15:0] ^ {a[23:16], 8'h5A}, a[15:0] + {8'h00, a[23:16]},
                ~a[15:0] ^ {8'h00, a[23:16]}, a[15:0] ^ {a[23:16], a[23:16]}};
    endfunction

    function automatic logic [15:0] pix(input int b, input int fr, input int l, input int p);
        logic [63:0] w;
        w = memw(addr_of(1'b0, b, fr, 0, l) + 24'(p / 4));
        return w[16*(p%4) +: 16];
    endfunction

    // expected burst list for a whole frame: each line split into chunks of at most 128 words
    task automatic plan(input bit il, input int b, input int fr, input int w, input int h);
        burst_t x;
        int     rem, off, n;
        if (il) q2.delete(); else q1.delete();
        for (int l = 0; l < h; l++) begin
            rem = (w + 3) / 4;
            off = 0;
            while (rem > 0) begin
                n   = rem < 128 ? rem : 128;
                x.a = addr_of(il, b, fr, 1, l) + 24'(off);
                x.n = 10'(n);
                if (il) q2.push_back(x); else q1.push_back(x);
                off += n;
                rem -= n;
            end
        end
    endtask

    initial begin
        mif.rd_burst_data_valid = 1'b0;
        mif.rd_burst_data       = '0;
        mif.burst_finish        = 1'b0;
        forever begin
            @(posedge vin_clk);
            #1;
            mif.rd_burst_data_valid = 1'b0;
            mif.burst_finish        = 1'b0;
            if (busy1) begin
                if (lat1 > 0) lat1--;
                else if (c1 < n1) begin
                    if ($urandom_range(99) >= 32'(gap_pct)) begin
                        mif.rd_burst_data_valid = 1'b1;
                        mif.rd_burst_data       = memw(a1 + 24'(c1));
                        c1++;
                    end
                end else begin
                    mif.burst_finish = 1'b1;
                    busy1            = 1'b0;
                end
            end
            if (mif.rd_burst_req && !prev1) begin
                chk("overlap", 64'(busy1), 64'd0);
                chk("req_expected", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) begin
                    burst_t x;
                    x = q1.pop_front();
                    chk("req_addr", 64'(mif.rd_burst_addr), 64'(x.a));
                    chk("req_len", 64'(mif.rd_burst_len), 64'(x.n));
                end
                busy1 = 1'b1;
                a1    = mif.rd_burst_addr;
                n1    = int'(mif.rd_burst_len);
                c1    = 0;
                lat1  = int'($urandom_range(1, 6));
            end
            prev1 = mif.rd_burst_req;
        end
    end

    initial begin
        mif2.rd_burst_data_valid = 1'b0;
        mif2.rd_burst_data       = '0;
        mif2.burst_finish        = 1'b0;
        forever begin
            @(posedge vin_clk);
            #1;
            mif2.burst_finish = 1'b0;
            if (busy2) begin
                if (lat2 > 0) lat2--;
                else begin
                    mif2.burst_finish = 1'b1;
                    busy2             = 1'b0;
                end
            end
            if (mif2.rd_burst_req && !prev2) begin
                chk("il_overlap", 64'(busy2), 64'd0);
                chk("il_req_expected", 64'(q2.size() > 0), 64'd1);
                if (q2.size() > 0) begin
                    burst_t x;
                    x = q2.pop_front();
                    chk("il_req_addr", 64'(mif2.rd_burst_addr), 64'(x.a));
                    chk("il_req_len", 64'(mif2.rd_burst_len), 64'(x.n));
                end
                busy2 = 1'b1;
                lat2  = int'($urandom_range(1, 6));
            end
            prev2 = mif2.rd_burst_req;
        end
    end

    task automatic tick(input logic de, input logic [15:0] exp);
        @(negedge vin_clk);
        if (pend) chk("pixel", 64'(vout_data), 64'(pend_exp));
        vout_de  = de;
        pend     = de;
        pend_exp = exp;
    endtask

    task automatic start_frame(input int w, input int h, input int b, input int fr);
        @(negedge vin_clk);
        vout_width  = 12'(w);
        vout_height = 12'(h);
        base_addr   = 2'(b);
        frame_addr  = 2'(fr);
        vout_vs     = 1'b1;
        repeat (2) @(negedge vin_clk);
        plan(1'b0, b, fr, w, h);
        plan(1'b1, 0, 1, w, h);
        chk("unf_clear", 64'(underflow), 64'd0);
        repeat (4) @(negedge vin_clk);
        vout_vs = 1'b0;
    endtask

    task automatic drive_frame(input int b, input int fr, input int w, input int h);
        repeat (600) @(negedge vin_clk);
        for (int l = 0; l < h; l++)
            for (int p = 0; p < w; p++) begin
                while ($urandom_range(2) == 0) tick(1'b0, 16'h0);
                tick(1'b1, pix(b, fr, l, p));
            end
        tick(1'b0, 16'h0);
        repeat (10) @(negedge vin_clk);
        chk("no_underflow", 64'(underflow), 64'd0);
        chk("reqs_left", 64'(q1.size()), 64'd0);
        chk("il_reqs_left", 64'(q2.size()), 64'd0);
        chk("il_empty_data", 64'(vout_data2), 64'd0);
        chk("il_underflow", 64'(underflow2), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge vin_clk);
        chk("rst_data", 64'(vout_data), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_req", 64'(mif.rd_burst_req), 64'd0);
        chk("rst_len", 64'(mif.rd_burst_len), 64'd0);
        chk("rst_addr", 64'(mif.rd_burst_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge vin_clk);
        vout_de = 1'b1;
        @(negedge vin_clk);
        vout_de = 1'b0;
        chk("unf_data", 64'(vout_data), 64'd0);
        chk("unf_set", 64'(underflow), 64'd1);
        repeat (5) @(negedge vin_clk);
        chk("unf_hold", 64'(underflow), 64'd1);
        start_frame(640, 4, 1, 2);
        drive_frame(1, 2, 640, 4);
        start_frame(201, 3, 2, 1);
        drive_frame(2, 1, 201, 3);
        // slow the data return so the next frame start lands inside a burst
        gap_pct = 90;
        start_frame(640, 4, 0, 3);
        k = 0;
        while (!(busy1 && c1 >= 4) && k < 3000) begin
            @(negedge vin_clk);
            k++;
        end
        chk("mid_burst_reached", 64'(busy1 && c1 >= 4), 64'd1);
        start_frame(640, 4, 0, 1);
        gap_pct = 20;
        drive_frame(0, 1, 640, 4);
        start_frame(640, 4, 1, 0);
        k = 0;
        while (!mif2.rd_burst_req && k < 200) begin
            @(negedge vin_clk);
            k++;
        end
        chk("il_req_before_rst", 64'(mif2.rd_burst_req), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_req", 64'(mif2.rd_burst_req), 64'd0);
        repeat (3) @(negedge vin_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
